// File: rtl/cp_insert_pkg.sv
// Shared OFDM definitions for the TX cyclic-prefix inserter: symbol/CP defaults,
// reader state encoding and the ping-pong RAM address-width helper.
package cp_insert_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int SYM_SHIFT_DEF  = 6;
  localparam int SYM_LEN_DEF    = 1 << SYM_SHIFT_DEF;
  localparam int CP_LEN_DEF     = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CP   = 2'd1;
  localparam logic [1:0] ST_BODY = 2'd2;

  typedef struct packed {
    logic [1:0] state;
    logic [1:0] bank_full;
    logic       wr_bank;
    logic       rd_bank;
  } dbg_t;

  // One extra address bit selects the ping-pong bank.
  function automatic int ram_addr_width(input int sym_shift);
    return sym_shift + 1;
  endfunction

endpackage

// File: rtl/cp_insert_if.sv
// Sample-stream bundle between the IFFT, the CP inserter and the DAC path.
interface cp_insert_if #(parameter int DATA_WIDTH = 32);
  import cp_insert_pkg::*;

  // Input side: a sample moves when input_strobe & input_ready are both high at a
  // clock edge; a strobe with input_ready low is dropped and flagged by overflow.
  // Output side: output_ready is a level; each cycle it is high (with enable) one
  // sample is committed, and output_strobe marks data_out valid for that cycle.
  logic                  enable;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  input_strobe;
  logic                  input_ready;
  logic                  output_ready;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  output_strobe;
  logic                  symbol_start;
  logic                  overflow;
  dbg_t                  dbg;

  modport master (
    output enable, data_in, input_strobe, output_ready,
    input  input_ready, data_out, output_strobe, symbol_start, overflow, dbg
  );

  modport slave (
    input  enable, data_in, input_strobe, output_ready,
    output input_ready, data_out, output_strobe, symbol_start, overflow, dbg
  );

endinterface

// File: rtl/dpram.sv
// Simple dual-port RAM: one write port, one read port with a registered output.
module dpram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clock,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] r_rd_data;

  always_ff @(posedge clock) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/cp_insert.sv
// Cyclic-prefix inserter: buffers whole symbols in a ping-pong RAM and replays
// each as its last CP_LEN samples followed by the full symbol.
module cp_insert
  import cp_insert_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int SYM_SHIFT  = SYM_SHIFT_DEF,
  parameter int CP_LEN     = CP_LEN_DEF
) (
  input logic        clock,
  input logic        reset,
  cp_insert_if.slave bus
);

  localparam int SYM_LEN = 1 << SYM_SHIFT;
  localparam int AW      = ram_addr_width(SYM_SHIFT);
  localparam logic [SYM_SHIFT-1:0] IDX_LAST = SYM_SHIFT'(SYM_LEN - 1);
  localparam logic [SYM_SHIFT-1:0] CP_START = SYM_SHIFT'(SYM_LEN - CP_LEN);

  logic [1:0]            r_bank_full;
  logic                  r_wr_bank;
  logic [SYM_SHIFT-1:0]  r_wr_addr;
  logic                  r_overflow;
  logic [1:0]            r_state;
  logic                  r_rd_bank;
  logic [SYM_SHIFT-1:0]  r_rd_idx;
  logic                  r_rd_en;
  logic                  r_rd_sos;
  logic [AW-1:0]         r_rd_addr;
  logic                  r_out_strobe;
  logic                  r_sym_start;

  logic                  w_input_ready;
  logic                  w_accept;
  logic                  w_wr_last;
  logic                  w_issue;
  logic [SYM_SHIFT-1:0]  w_issue_idx;
  logic                  w_idx_last;
  logic                  w_body_done;
  logic                  w_sos;
  logic [1:0]            w_bank_full_nxt;
  logic [DATA_WIDTH-1:0] w_rd_data;

  // Writer side
  assign w_input_ready = bus.enable & ~r_bank_full[r_wr_bank];
  assign w_accept      = bus.input_strobe & w_input_ready;
  assign w_wr_last     = w_accept & (r_wr_addr == IDX_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_addr  <= '0;
      r_wr_bank  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= bus.input_strobe & ~w_input_ready;
      if (w_accept) r_wr_addr <= r_wr_addr + 1'b1;
      if (w_wr_last) r_wr_bank <= ~r_wr_bank;
    end
  end

  // Reader side: the IDLE issue is the first prefix read, so it shares the CP
  // index/advance logic and CP_LEN == 1 falls straight through to BODY.
  assign w_issue     = bus.enable & bus.output_ready &
                       ((r_state != ST_IDLE) | r_bank_full[r_rd_bank]);
  assign w_issue_idx = (r_state == ST_IDLE) ? CP_START : r_rd_idx;
  assign w_idx_last  = (w_issue_idx == IDX_LAST);
  assign w_body_done = w_issue & (r_state == ST_BODY) & w_idx_last;
  assign w_sos       = w_issue & ((r_state == ST_IDLE) |
                                  ((r_state == ST_CP) & (r_rd_idx == CP_START)));

  // Set and clear never hit the same bank in one cycle.
  always_comb begin
    w_bank_full_nxt = r_bank_full;
    if (w_body_done) w_bank_full_nxt[r_rd_bank] = 1'b0;
    if (w_wr_last)   w_bank_full_nxt[r_wr_bank] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) r_bank_full <= 2'b00;
    else       r_bank_full <= w_bank_full_nxt;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_rd_idx  <= '0;
      r_rd_bank <= 1'b0;
    end else if (w_issue) begin
      case (r_state)
        ST_IDLE, ST_CP: begin
          if (w_idx_last) begin
            r_state  <= ST_BODY;
            r_rd_idx <= '0;
          end else begin
            r_state  <= ST_CP;
            r_rd_idx <= w_issue_idx + 1'b1;
          end
        end
        ST_BODY: begin
          if (w_idx_last) begin
            r_rd_bank <= ~r_rd_bank;
            if (r_bank_full[~r_rd_bank]) begin
              r_state  <= ST_CP;
              r_rd_idx <= CP_START;
            end else begin
              r_state  <= ST_IDLE;
              r_rd_idx <= '0;
            end
          end else begin
            r_rd_idx <= r_rd_idx + 1'b1;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_rd_idx <= '0;
        end
      endcase
    end
  end

  // Read pipeline: issued reads always complete regardless of enable/output_ready.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd_en      <= 1'b0;
      r_rd_sos     <= 1'b0;
      r_out_strobe <= 1'b0;
      r_sym_start  <= 1'b0;
    end else begin
      r_rd_en      <= w_issue;
      r_rd_sos     <= w_sos;
      r_out_strobe <= r_rd_en;
      r_sym_start  <= r_rd_sos;
    end
  end

  always_ff @(posedge clock) begin
    if (w_issue) r_rd_addr <= {r_rd_bank, w_issue_idx};
  end

  dpram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (AW)
  ) u_ram (
    .clock     (clock),
    .i_wr_en   (w_accept),
    .i_wr_addr ({r_wr_bank, r_wr_addr}),
    .i_wr_data (bus.data_in),
    .i_rd_en   (r_rd_en),
    .i_rd_addr (r_rd_addr),
    .o_rd_data (w_rd_data)
  );

  assign bus.input_ready   = w_input_ready;
  assign bus.data_out      = w_rd_data;
  assign bus.output_strobe = r_out_strobe;
  assign bus.symbol_start  = r_sym_start;
  assign bus.overflow      = r_overflow;
  assign bus.dbg           = '{state: r_state, bank_full: r_bank_full,
                               wr_bank: r_wr_bank, rd_bank: r_rd_bank};

endmodule

// File: tb/tb_cp_insert.sv
// Scoreboard bench for cp_insert: CP_LEN=16 main instance plus a CP_LEN=64 corner instance.
module tb_cp_insert;
  import cp_insert_pkg::*;

  localparam int W  = 32;
  localparam int SL = 64;
  localparam int CP = 16;
  localparam int TMO = 5000;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  cp_insert_if #(.DATA_WIDTH(W)) bus ();
  cp_insert_if #(.DATA_WIDTH(W)) bus2 ();

  cp_insert #(.DATA_WIDTH(W), .SYM_SHIFT(6), .CP_LEN(CP)) dut (
    .clock (clock), .reset (reset), .bus (bus)
  );
  cp_insert #(.DATA_WIDTH(W), .SYM_SHIFT(6), .CP_LEN(SL)) dut2 (
    .clock (clock), .reset (reset), .bus (bus2)
  );

  int total = 0;
  int bad   = 0;
  logic [W:0]   exp_q[$];
  logic [W:0]   exp2_q[$];
  logic [W-1:0] acc[$];
  int neg_cyc = 0, out_cnt = 0, out2_cnt = 0, first_cyc = 0, last_cyc = 0;
  int ovf_cnt = 0, consec = 0, knob_mode = 0, last_drive_cyc = 0;
  logic prev_strobe = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: output k of a symbol is sample (SL-cp+k) for k<cp, else sample k-cp.
  task automatic push_expected(input int cp, input logic [W-1:0] s[SL], input bit second);
    int idx;
    logic [W:0] e;
    for (int k = 0; k < cp + SL; k++) begin
      idx = (k < cp) ? (SL - cp + k) : (k - cp);
      e = {(k == 0), s[idx]};
      if (second) exp2_q.push_back(e);
      else        exp_q.push_back(e);
    end
  endtask

  task automatic note_accept(input logic [W-1:0] v);
    logic [W-1:0] s[SL];
    acc.push_back(v);
    if (acc.size() == SL) begin
      for (int i = 0; i < SL; i++) s[i] = acc[i];
      push_expected(CP, s, 1'b0);
      acc.delete();
    end
  endtask

  // Called at a negedge; offers v only when input_ready is high, returns at the next negedge.
  task automatic drive(input logic [W-1:0] v);
    int w;
    w = 0;
    bus.input_strobe = 1'b0;
    #1;
    while (!bus.input_ready && w < TMO) begin
      @(negedge clock); #1; w++;
    end
    if (w >= TMO) begin
      total++; bad++;
      $display("FAIL drive_timeout: got ready=0 for %0d cycles expected ready", w);
    end else begin
      bus.data_in = v;
      bus.input_strobe = 1'b1;
      last_drive_cyc = neg_cyc;
      note_accept(v);
    end
    @(negedge clock);
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while ((exp_q.size() != 0 || exp2_q.size() != 0) && w < TMO) begin
      @(negedge clock); w++;
    end
    check("drain_in_time", (w < TMO), 1);
    repeat (4) @(negedge clock);
  endtask

  // Monitor / scoreboard
  initial forever begin
    logic [W:0] e;
    @(negedge clock);
    neg_cyc++;
    if (bus.overflow) ovf_cnt++;
    if (bus.symbol_start && !bus.output_strobe) begin
      total++; bad++;
      $display("FAIL sos_without_strobe: got symbol_start=1 expected 0");
    end
    if (bus.output_strobe) begin
      if (knob_mode == 1 && prev_strobe) consec++;
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_out: got %0h expected no output", bus.data_out);
      end else begin
        e = exp_q.pop_front();
        check("out_sample", {bus.symbol_start, bus.data_out}, e);
      end
      if (out_cnt == 0) first_cyc = neg_cyc;
      last_cyc = neg_cyc;
      out_cnt++;
    end
    prev_strobe = bus.output_strobe;
    if (bus2.output_strobe) begin
      if (exp2_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_out2: got %0h expected no output", bus2.data_out);
      end else begin
        e = exp2_q.pop_front();
        check("out2_sample", {bus2.symbol_start, bus2.data_out}, e);
      end
      out2_cnt++;
    end
  end

  // Output-side / enable stimulus knobs
  initial forever begin
    @(negedge clock);
    case (knob_mode)
      1: bus.output_ready = ~bus.output_ready;
      2: begin
        bus.output_ready = ($urandom_range(0, 3) != 0);
        bus.enable       = ($urandom_range(0, 7) != 0);
      end
      default: ;
    endcase
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] s2[SL];
    int w;
    bus.enable = 1'b1; bus.output_ready = 1'b1; bus.input_strobe = 1'b0; bus.data_in = '0;
    bus2.enable = 1'b1; bus2.output_ready = 1'b1; bus2.input_strobe = 1'b0; bus2.data_in = '0;

    // Reset state
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_strobe", bus.output_strobe, 0);
    check("rst_sos", bus.symbol_start, 0);
    check("rst_overflow", bus.overflow, 0);
    check("rst_state", bus.dbg.state, ST_IDLE);
    check("rst_bank_full", bus.dbg.bank_full, 0);
    check("rst_input_ready", bus.input_ready, 1);
    reset = 1'b0;
    @(negedge clock);

    // Ramp symbol and minimum latency
    out_cnt = 0;
    for (int i = 0; i < SL; i++) drive(W'(i));
    bus.input_strobe = 1'b0;
    wait_drain();
    check("ramp_count", out_cnt, 80);
    check("ramp_latency", first_cyc - last_drive_cyc, 3);

    // Streaming: three back-to-back symbols
    out_cnt = 0; ovf_cnt = 0;
    for (int i = 0; i < 3 * SL; i++) begin
      drive($urandom);
      if (i == 2 * SL - 1) begin
        bus.input_strobe = 1'b0;
        #1;
        check("stream_ready_drop", bus.input_ready, 0);
        w = 0;
        while (!bus.input_ready && w < TMO) begin
          @(negedge clock); #1; w++;
        end
        check("stream_ready_back", (out_cnt >= 78 && out_cnt <= 80), 1);
        @(negedge clock);
      end
    end
    bus.input_strobe = 1'b0;
    wait_drain();
    check("stream_count", out_cnt, 240);
    check("stream_no_gap", last_cyc - first_cyc, 239);
    check("stream_no_overflow", ovf_cnt, 0);

    // Backpressure: output_ready toggles every cycle
    out_cnt = 0; consec = 0;
    knob_mode = 1;
    for (int i = 0; i < SL; i++) drive($urandom);
    bus.input_strobe = 1'b0;
    wait_drain();
    knob_mode = 0;
    bus.output_ready = 1'b1;
    check("bp_count", out_cnt, 80);
    check("bp_no_consecutive", consec, 0);
    check("bp_span", last_cyc - first_cyc, 158);

    // Overflow with both banks full
    bus.output_ready = 1'b0;
    out_cnt = 0; ovf_cnt = 0;
    for (int i = 0; i < 2 * SL; i++) drive($urandom);
    bus.input_strobe = 1'b0;
    @(negedge clock); #1;
    check("ovf_ready_low", bus.input_ready, 0);
    bus.data_in = 32'hDEAD;
    bus.input_strobe = 1'b1;
    @(negedge clock);
    bus.input_strobe = 1'b0;
    repeat (3) @(negedge clock);
    check("ovf_pulses", ovf_cnt, 1);
    check("ovf_ready_stays_low", bus.input_ready, 0);
    check("ovf_no_output", out_cnt, 0);
    bus.output_ready = 1'b1;
    wait_drain();
    check("ovf_drain_count", out_cnt, 160);

    // Reset in the middle of an output symbol
    out_cnt = 0;
    for (int i = 0; i < SL; i++) drive(W'(i));
    bus.input_strobe = 1'b0;
    w = 0;
    while (out_cnt < 30 && w < TMO) begin
      @(negedge clock); #1; w++;
    end
    check("reset_reached_out30", (out_cnt >= 30), 1);
    reset = 1'b1;
    @(posedge clock); #1;
    exp_q.delete();
    acc.delete();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    out_cnt = 0;
    repeat (10) @(negedge clock);
    check("reset_quiet", out_cnt, 0);
    check("reset_banks_empty", bus.dbg.bank_full, 0);
    for (int i = 0; i < SL; i++) drive(W'(100 + i));
    bus.input_strobe = 1'b0;
    wait_drain();
    check("reset_new_count", out_cnt, 80);

    // Randomized strobes, output_ready and enable
    out_cnt = 0; ovf_cnt = 0;
    knob_mode = 2;
    for (int i = 0; i < 4 * SL; i++) begin
      bus.input_strobe = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clock);
      drive($urandom);
    end
    bus.input_strobe = 1'b0;
    #1;
    knob_mode = 0;
    bus.enable = 1'b1;
    bus.output_ready = 1'b1;
    wait_drain();
    check("rand_count", out_cnt, 4 * 80);
    check("rand_no_overflow", ovf_cnt, 0);

    // CP_LEN = SYM_LEN corner on the second instance
    out2_cnt = 0;
    #1;
    for (int i = 0; i < SL; i++) begin
      bus2.data_in = W'(i);
      bus2.input_strobe = 1'b1;
      s2[i] = W'(i);
      @(negedge clock); #1;
    end
    bus2.input_strobe = 1'b0;
    push_expected(SL, s2, 1'b1);
    wait_drain();
    check("cp64_count", out2_cnt, 128);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cp_insert.md
Name: cp_insert

Overview:
- Transmit-side cyclic-prefix inserter for the OFDM TX chain; sits between the IFFT output and the DAC/TX sample stream.
- Buffers one OFDM symbol of 2^SYM_SHIFT time-domain samples in a ping-pong RAM.
- Emits each symbol as its last CP_LEN samples followed by the full symbol.
- Mirrors the RX-side RAM delay line and CP-stripping path.

Parameters:
- DATA_WIDTH, 32: sample width, packed I/Q.
- SYM_SHIFT, 6: log2 of symbol length; SYM_LEN = 1<<SYM_SHIFT.
- CP_LEN, 16: cyclic prefix length in samples. Legal range is 1 ≤ CP_LEN ≤ SYM_LEN.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- enable  in  1  global run enable.
- data_in  in  DATA_WIDTH  input sample.
- input_strobe  in  1  data_in is valid this cycle.
- input_ready  out  1  a write bank is free; strobes are accepted only when high.
- output_ready  in  1  downstream can take one sample per cycle; level-sensitive.
- data_out  out  DATA_WIDTH  output sample.
- output_strobe  out  1  data_out is valid this cycle.
- symbol_start  out  1  pulses with the first CP sample of each symbol.
- overflow  out  1  one-cycle pulse when a strobe is dropped.

Behaviour:
- Reset and clock: reset is synchronous and active-high; clock is clock.
- Reset state:
  - output_strobe, symbol_start and overflow are 0.
  - Both banks are empty; wr_addr = rd_idx = 0; wr_bank = rd_bank = 0.
  - FSM is in IDLE; data_out is don't-care.
  - Reset mid-symbol discards all buffered data; no partial symbol is ever emitted afterwards.
- Memory:
  - 2*SYM_LEN words, address = {bank, index}.
  - Write port is owned by the writer, read port by the reader.
  - Read latency is 1 cycle.
  - The writer only touches banks with bank_full = 0 and the reader only touches banks with bank_full = 1, so no same-address collision is possible.
- Writer:
  - input_ready = enable & !bank_full[wr_bank].
  - Accept = input_strobe & input_ready. On accept: write {wr_bank, wr_addr} and increment wr_addr.
  - When wr_addr == SYM_LEN-1 on accept: wr_addr wraps to 0, bank_full[wr_bank] is set, wr_bank toggles.
  - A strobe while input_ready = 0 is dropped and overflow pulses the next cycle.
- Reader FSM:
  - IDLE: if enable & output_ready & bank_full[rd_bank], issue a read of index SYM_LEN-CP_LEN, then go to CP.
  - CP: each enabled cycle with output_ready high, issue a read and increment rd_idx. After issuing SYM_LEN-1, wrap to 0 and go to BODY.
  - BODY: issue index 0..SYM_LEN-1. After issuing SYM_LEN-1:
    - clear bank_full[rd_bank] and toggle rd_bank;
    - if the other bank is full and output_ready is high, go directly to CP (back-to-back, no gap); otherwise go to IDLE.
- Output timing:
  - output_strobe is registered and asserts exactly 1 cycle after each issued read. Issued reads always complete, even if enable or output_ready drops.
  - symbol_start asserts with output_strobe for the IDLE→CP issue and for the BODY→CP back-to-back issue.
  - Minimum latency: the last input is accepted at edge t, the first output_strobe is high after edge t+2.
  - Sustained throughput is SYM_LEN+CP_LEN output cycles per symbol. Input may arrive at up to 1/cycle, and backpressure comes via input_ready.
- Simultaneous set and clear of bank_full in the same cycle always targets different banks; both take effect.
- enable low freezes writer and reader state; input_ready is 0 and no new reads are issued.

Decomposition:
- Shared OFDM package holds the SYM_LEN/CP_LEN defaults (64/16), the FSM state encoding (IDLE, CP, BODY) and the address-width helper (SYM_SHIFT+1).
- Storage is the existing dpram instantiated once, DATA_WIDTH x (SYM_SHIFT+1).
- Counters and FSM are in-module; no further sub-module.

Test Plan:
- Ramp symbol: 64 inputs 0..63 at 1/cycle with output_ready = 1 → 80 outputs 48..63,0..63; symbol_start on the first (value 48) only; first output_strobe 2 cycles after input 63.
- Streaming: 3 symbols with continuous input_strobe →
  - input_ready drops after the 128th accept and reasserts when bank 0 drains;
  - 240 outputs with no gap between symbols;
  - symbol_start at outputs 0, 80 and 160;
  - no overflow.
- Backpressure: output_ready toggling 1/0 each cycle during a symbol → outputs 48..63,0..63 spread over 160 cycles, exactly one output_strobe per high output_ready (one cycle delayed), data in order.
- Overflow: fill both banks with output_ready = 0, then strobe value 0xDEAD → overflow pulses once, input_ready stays 0, and 0xDEAD never appears on data_out.
- Reset mid-operation: reset asserted at output 30 of symbol 0, then a fresh ramp 100..163 → no output_strobe during or after reset until the new symbol; new output is 148..163,100..163.
- Parameter corner CP_LEN = 64: ramp 0..63 → 128 outputs 0..63,0..63 with a single symbol_start.
